// File: rtl/fetch_queue_pkg.sv
// Shared types for the fetch-to-decode instruction buffer: RV32I word,
// branch-prediction bundle and the stored queue entry.
package fetch_queue_pkg;

    typedef logic [31:0] rv32i_word;

    typedef struct packed {
        logic [2:0] bhr;
        logic       taken;
        rv32i_word  btb_address;
    } predict_regs;

    typedef struct packed {
        rv32i_word   pc;
        rv32i_word   instr;
        predict_regs predict;
    } fetch_entry;

    localparam int FQ_DEFAULT_DEPTH = 4;

    function automatic int fq_count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Enqueue (from fetch) and dequeue (to decode) handshake bundle of the fetch queue.
import fetch_queue_pkg::*;

interface fetch_queue_if;

    logic        enq_valid;
    rv32i_word   enq_pc;
    rv32i_word   enq_instr;
    predict_regs enq_predict;
    logic        enq_ready;

    logic        deq_valid;
    rv32i_word   deq_pc;
    rv32i_word   deq_instr;
    predict_regs deq_predict;
    logic        deq_ready;

    // master drives fetch data and decode's ready; slave is the queue itself
    modport master (
        output enq_valid, enq_pc, enq_instr, enq_predict, deq_ready,
        input  enq_ready, deq_valid, deq_pc, deq_instr, deq_predict
    );

    modport slave (
        input  enq_valid, enq_pc, enq_instr, enq_predict, deq_ready,
        output enq_ready, deq_valid, deq_pc, deq_instr, deq_predict
    );

endinterface

// File: rtl/fetch_queue_ptr.sv
// CW-bit circular-buffer pointer: low bits index storage, MSB is the wrap bit.
// Load has priority over increment; ptr_nxt exposes the value taken on the next edge.
module fifo_ptr #(
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          inc,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic [CW-1:0] ptr,
    output logic [CW-1:0] ptr_nxt
);

    always_comb begin
        ptr_nxt = ptr;
        if (load)
            ptr_nxt = load_val;
        else if (inc)
            ptr_nxt = ptr + CW'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            ptr <= '0;
        else
            ptr <= ptr_nxt;
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction buffer between fetch and decode: DEPTH-entry circular FIFO of
// {pc, instr, predict}, drained in order, flushed on execute redirect.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = FQ_DEFAULT_DEPTH,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            reset_n,
    fetch_queue_if.slave    q,
    input  logic            flush,
    input  logic            flush_drop_reset,
    output logic            stall_out,
    output logic [CW-1:0]   count,
    output logic [31:0]     flush_drop_count
);

    localparam int AW = CW - 1;

    fetch_entry    mem [DEPTH];
    fetch_entry    wr_entry;
    logic [CW-1:0] rptr, wptr, rptr_nxt, wptr_nxt;
    logic          empty, full;
    logic          enq_fire, deq_fire;

    function automatic logic [31:0] sat_add32(input logic [31:0] a,
                                              input logic [CW-1:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + 33'(b);
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

    assign empty = (rptr == wptr);
    assign full  = (rptr[AW-1:0] == wptr[AW-1:0]) && (rptr[CW-1] != wptr[CW-1]);

    // Fires are gated on full/empty too, so the pointers can never cross.
    assign enq_fire = q.enq_valid & ~full  & ~flush;
    assign deq_fire = q.deq_ready & ~empty & ~flush;

    fifo_ptr #(.CW(CW)) u_wptr (
        .clk      (clk),
        .reset_n  (reset_n),
        .inc      (enq_fire),
        .load     (1'b0),
        .load_val ({CW{1'b0}}),
        .ptr      (wptr),
        .ptr_nxt  (wptr_nxt)
    );

    // Flush collapses the read pointer onto the write pointer.
    fifo_ptr #(.CW(CW)) u_rptr (
        .clk      (clk),
        .reset_n  (reset_n),
        .inc      (deq_fire),
        .load     (flush),
        .load_val (wptr),
        .ptr      (rptr),
        .ptr_nxt  (rptr_nxt)
    );

    assign wr_entry = '{pc: q.enq_pc, instr: q.enq_instr, predict: q.enq_predict};

    always_ff @(posedge clk) begin
        if (enq_fire)
            mem[wptr[AW-1:0]] <= wr_entry;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            count <= '0;
        else
            count <= wptr_nxt - rptr_nxt;
    end

    // A clear coinciding with a flush wins over the accumulation.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            flush_drop_count <= '0;
        else if (flush_drop_reset)
            flush_drop_count <= '0;
        else if (flush)
            flush_drop_count <= sat_add32(flush_drop_count, count);
    end

    assign q.enq_ready   = ~full;
    assign stall_out     = full;
    assign q.deq_valid   = ~empty;
    assign q.deq_pc      = mem[rptr[AW-1:0]].pc;
    assign q.deq_instr   = mem[rptr[AW-1:0]].instr;
    assign q.deq_predict = mem[rptr[AW-1:0]].predict;

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: stimulus pushes accepted entries, a
// negedge monitor pops and compares every dequeue.
import fetch_queue_pkg::*;

module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          flush = 1'b0;
    logic          flush_drop_reset = 1'b0;
    logic          stall_out;
    logic [CW-1:0] count;
    logic [31:0]   flush_drop_count;

    fetch_queue_if fq ();

    fetch_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .q                (fq),
        .flush            (flush),
        .flush_drop_reset (flush_drop_reset),
        .stall_out        (stall_out),
        .count            (count),
        .flush_drop_count (flush_drop_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    fetch_entry sb [$];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic drive_enq(input logic [31:0] pc, input logic [31:0] instr,
                             input predict_regs pr);
        fq.enq_valid   = 1'b1;
        fq.enq_pc      = pc;
        fq.enq_instr   = instr;
        fq.enq_predict = pr;
    endtask

    function automatic predict_regs mk_pr(input logic [31:0] pc);
        predict_regs p;
        p.bhr         = pc[4:2];
        p.taken       = pc[2];
        p.btb_address = pc + 32'h1000;
        return p;
    endfunction

    // One clock: record accepted enqueue / flush at negedge, return at posedge+1.
    task automatic step();
        fetch_entry e;
        @(negedge clk);
        if (reset_n && fq.enq_valid && fq.enq_ready && !flush) begin
            e.pc      = fq.enq_pc;
            e.instr   = fq.enq_instr;
            e.predict = fq.enq_predict;
            sb.push_back(e);
        end
        if (flush)
            sb.delete();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every dequeue that will fire on the next rising edge.
    always @(negedge clk) begin
        fetch_entry e;
        if (reset_n) begin
            chk("enq_ready_vs_count", 64'(fq.enq_ready), 64'(count != CW'(DEPTH)));
            chk("deq_valid_vs_count", 64'(fq.deq_valid), 64'(count != '0));
            chk("stall_vs_ready",     64'(stall_out),    64'(!fq.enq_ready));
            if (fq.deq_valid && fq.deq_ready && !flush) begin
                if (sb.size() == 0) begin
                    chk("deq_unexpected", 64'(fq.deq_pc), 64'hDEAD_0000_0000);
                end else begin
                    e = sb.pop_front();
                    chk("deq_pc",      64'(fq.deq_pc),      64'(e.pc));
                    chk("deq_instr",   64'(fq.deq_instr),   64'(e.instr));
                    chk("deq_predict", 64'(fq.deq_predict), 64'(e.predict));
                end
            end
        end
    end

    initial begin
        predict_regs pr;
        fq.enq_valid   = 1'b0;
        fq.enq_pc      = '0;
        fq.enq_instr   = '0;
        fq.enq_predict = '0;
        fq.deq_ready   = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_deq_valid", 64'(fq.deq_valid), 64'd0);
        chk("rst_enq_ready", 64'(fq.enq_ready), 64'd1);
        chk("rst_stall",     64'(stall_out),    64'd0);
        chk("rst_count",     64'(count),        64'd0);
        chk("rst_fdc",       64'(flush_drop_count), 64'd0);
        reset_n = 1'b1;

        // Fill to full with decode stalled
        for (int i = 0; i < 4; i++) begin
            drive_enq(32'h60 + 32'(4 * i), 32'h0001_0060 + 32'(4 * i), mk_pr(32'h60 + 32'(4 * i)));
            step();
        end
        chk("full_count",     64'(count),        64'd4);
        chk("full_stall",     64'(stall_out),    64'd1);
        chk("full_enq_ready", 64'(fq.enq_ready), 64'd0);
        chk("full_head_pc",   64'(fq.deq_pc),    64'h60);
        drive_enq(32'h70, 32'h0001_0070, mk_pr(32'h70));
        step();
        fq.enq_valid = 1'b0;
        chk("fifth_count",   64'(count),     64'd4);
        chk("fifth_head_pc", 64'(fq.deq_pc), 64'h60);

        // Drain in order
        fq.deq_ready = 1'b1;
        repeat (4) step();
        fq.deq_ready = 1'b0;
        chk("drain_deq_valid", 64'(fq.deq_valid), 64'd0);
        chk("drain_count",     64'(count),        64'd0);
        chk("drain_sb_empty",  64'(sb.size()),    64'd0);

        // Streaming: one in, one out every cycle
        fq.deq_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            pr.bhr         = 3'(i);
            pr.taken       = 1'b1;
            pr.btb_address = 32'h100;
            drive_enq(32'h300 + 32'(4 * i), 32'hA000_0000 + 32'(i), pr);
            step();
            chk("stream_count",   64'(count),              64'd1);
            chk("stream_head_pc", 64'(fq.deq_pc),          64'(32'h300 + 32'(4 * i)));
            chk("stream_taken",   64'(fq.deq_predict.taken), 64'd1);
        end
        fq.enq_valid = 1'b0;
        step();
        fq.deq_ready = 1'b0;
        chk("stream_end_count", 64'(count),     64'd0);
        chk("stream_sb_empty",  64'(sb.size()), 64'd0);

        // Flush with three queued and a colliding enqueue of 0x200
        for (int i = 0; i < 3; i++) begin
            drive_enq(32'h80 + 32'(4 * i), 32'h0001_0080 + 32'(4 * i), mk_pr(32'h80 + 32'(4 * i)));
            step();
        end
        chk("pre_flush_count", 64'(count), 64'd3);
        drive_enq(32'h200, 32'h0001_0200, mk_pr(32'h200));
        flush = 1'b1;
        step();
        flush = 1'b0;
        fq.enq_valid = 1'b0;
        chk("flush_count",     64'(count),            64'd0);
        chk("flush_deq_valid", 64'(fq.deq_valid),     64'd0);
        chk("flush_fdc",       64'(flush_drop_count), 64'd3);
        fq.deq_ready = 1'b1;
        repeat (2) step();
        fq.deq_ready = 1'b0;
        chk("flush_200_absent", 64'(fq.deq_valid), 64'd0);

        // Clear coinciding with flush wins
        for (int i = 0; i < 2; i++) begin
            drive_enq(32'h90 + 32'(4 * i), 32'h0001_0090, mk_pr(32'h90));
            step();
        end
        fq.enq_valid = 1'b0;
        flush = 1'b1;
        flush_drop_reset = 1'b1;
        step();
        flush = 1'b0;
        flush_drop_reset = 1'b0;
        chk("clr_with_flush_fdc",   64'(flush_drop_count), 64'd0);
        chk("clr_with_flush_count", 64'(count),            64'd0);
        drive_enq(32'h94, 32'h0001_0094, mk_pr(32'h94));
        step();
        fq.enq_valid = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_one_fdc", 64'(flush_drop_count), 64'd1);
        flush_drop_reset = 1'b1;
        step();
        flush_drop_reset = 1'b0;
        chk("clr_alone_fdc", 64'(flush_drop_count), 64'd0);

        // Asynchronous reset between edges with two queued
        for (int i = 0; i < 2; i++) begin
            drive_enq(32'hA0 + 32'(4 * i), 32'h0001_00A0, mk_pr(32'hA0));
            step();
        end
        fq.enq_valid = 1'b0;
        chk("pre_arst_count", 64'(count), 64'd2);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_deq_valid", 64'(fq.deq_valid), 64'd0);
        chk("arst_count",     64'(count),        64'd0);
        chk("arst_enq_ready", 64'(fq.enq_ready), 64'd1);
        sb.delete();
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Post-reset sanity
        drive_enq(32'hB0, 32'h0001_00B0, mk_pr(32'hB0));
        step();
        fq.enq_valid = 1'b0;
        chk("post_rst_head_pc", 64'(fq.deq_pc), 64'hB0);
        fq.deq_ready = 1'b1;
        step();
        fq.deq_ready = 1'b0;
        chk("post_rst_count",    64'(count),     64'd0);
        chk("post_rst_sb_empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction buffer between the fetch stage and decode.
- Each cycle it captures one fetched instruction word from fetch, together with its PC and branch-prediction bundle.
- Decode drains it in order through a valid/ready handshake.
- It decouples instruction-cache response timing from decode stalls, and it is flushed when execute redirects the PC on a misprediction.

Parameters:
- DEPTH, 4, number of entries; power of two, at least 2.
- CW, $clog2(DEPTH)+1, width of the occupancy count.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- enq_valid  in  1  fetch presents a valid instruction (cache resp_a with a non-redirected PC).
- enq_pc  in  32  PC of the fetched instruction (rv32i_word).
- enq_instr  in  32  instruction word (rdata_a).
- enq_predict  in  predict_regs  prediction bundle: bhr[2:0], taken, btb_address[31:0].
- enq_ready  out  1  queue can accept this cycle; equals !full.
- stall_out  out  1  to fetch stall_in; equals full.
- deq_valid  out  1  head entry valid; equals !empty.
- deq_pc  out  32  head PC.
- deq_instr  out  32  head instruction.
- deq_predict  out  predict_regs  head prediction bundle.
- deq_ready  in  1  decode accepts head this cycle.
- flush  in  1  mispredict or redirect from execute; discards all entries.
- count  out  CW  current occupancy, 0..DEPTH.
- flush_drop_count  out  32  cumulative number of entries discarded by flush (performance counter).
- flush_drop_reset  in  1  synchronous clear of flush_drop_count.

Behaviour:
- Storage: DEPTH-entry circular buffer.
  - Entries are {pc, instr, predict}.
  - Read and write pointers are CW bits wide: the low bits index the array, the MSB is the wrap bit.
  - empty when the pointers are equal.
  - full when the low bits are equal and the MSBs differ.
- Reset (reset_n = 0, async):
  - Pointers and count go to 0; flush_drop_count goes to 0.
  - Outputs: deq_valid = 0, enq_ready = 1, stall_out = 0.
  - Entry storage is not reset; deq_pc/deq_instr/deq_predict are don't-care while deq_valid = 0.
- Enqueue fire = enq_valid & enq_ready & !flush.
  - The entry is written at wptr and wptr increments on the rising edge.
- Dequeue fire = deq_valid & deq_ready & !flush.
  - rptr increments on the rising edge.
- Data path:
  - deq_* are driven combinationally from array[rptr].
  - There is no bypass: minimum enqueue-to-deq_valid latency is 1 cycle.
  - Fall-through is forbidden; an entry must be registered first.
- Simultaneous enqueue and dequeue:
  - Both fire and count is unchanged.
  - When full, enq_ready = 0 regardless of deq_ready, so there is no same-cycle refill of a full queue.
- Count:
  - count = wptr - rptr (CW-bit modular subtraction).
  - Registered, so it updates in the cycle after a fire.
- Wrap-around: pointers wrap naturally at 2*DEPTH. The array index wraps at DEPTH.
- Flush:
  - Highest priority: on the edge with flush = 1, rptr takes wptr's value, giving empty.
  - An enqueue in the same cycle is dropped; a dequeue in the same cycle does not fire, so decode must ignore the head.
  - flush_drop_count increments by the count in that cycle. It saturates at 2^32-1.
- flush_drop_reset:
  - Clears flush_drop_count on the edge.
  - If it coincides with a flush, the clear wins and the result is 0.
- Enqueue while full and dequeue while empty are blocked by the handshake.
  - The bench asserts that neither ever fires.
  - The RTL also gates the fires internally, so pointers never pass each other.
- Reset asserted mid-operation empties the queue immediately, asynchronously, without waiting for a clock edge.

Decomposition:
- The predict_regs struct and rv32i_word already live in rv32i_types. Add a fetch_entry struct {rv32i_word pc; rv32i_word instr; predict_regs predict;} there as well.
- Natural sub-module: fifo_ptr. It is a CW-bit pointer with an increment input and async active-low reset, and it is instantiated for rptr and wptr.
- flush_drop_count is built inline as a 32-bit saturating register.

Test Plan:
- Reset, then enqueue pc 0x60, 0x64, 0x68, 0x6C with deq_ready = 0 → count reaches 4, stall_out = 1, enq_ready = 0; a 5th enqueue of pc 0x70 is not accepted.
- From full, deq_ready = 1 for 4 cycles → deq_pc reads 0x60, 0x64, 0x68, 0x6C in order, then deq_valid = 0 and count = 0.
- Continuous enqueue and dequeue every cycle for 20 cycles → pointers wrap at least twice, count stays 1, and deq_pc equals enq_pc delayed by one cycle with instr and predict fields intact (e.g., taken = 1, btb_address 0x100).
- Three entries queued, then flush with enq_valid = 1 (pc 0x200) → next cycle count = 0, deq_valid = 0, flush_drop_count = 3, and 0x200 is absent.
- Assert reset_n low between clock edges with 2 entries queued → deq_valid drops before the next edge and count = 0; pulsing flush_drop_reset together with a flush gives flush_drop_count = 0.
